// File: rtl/multicycle_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_cpu : RV32I-subset core, FETCH/DECODE/EXEC/MEM/WB state machine |
// |                  sharing one req/ack word memory port for code and data.   |
// | Option macro   : MULTICYCLE_CPU_TRAP_EN (illegal opcode halts in TRAP).    |
// | Revision       : 1.0 - initial release                                     |
// +----------------------------------------------------------------------------+
module multicycle_cpu #(
  parameter int               NREG     = 32,
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              zero,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int        c_REG_AW = $clog2(NREG);
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_LUI = 7'b0110111;
  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_BR  = 7'b1100011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MULTICYCLE_CPU_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_imm;
  logic [31:0]       r_alu;
  logic [31:0]       r_mdr;
  logic              r_zero;
  logic              r_retire;
  logic              r_halted;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_regs [NREG];

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic w_is_r, w_add, w_sub, w_and, w_or, w_xor, w_slt;
  logic w_addi, w_lui, w_lw, w_sw, w_beq, w_bne, w_jal;
  logic w_uses_rd, w_uses_rs1, w_uses_rs2, w_reg_bad, w_legal;
  logic w_take, w_wb_en;
  logic [31:0]       w_imm;
  logic [31:0]       w_alu;
  logic [31:0]       w_rs1_val;
  logic [31:0]       w_rs2_val;
  logic [31:0]       w_wb_data;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];
  assign w_rd     = r_ir[11:7];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];

  assign w_is_r = (w_opcode == c_OP_R);
  assign w_add  = w_is_r && (w_funct7 == 7'b0000000) && (w_funct3 == 3'b000);
  assign w_sub  = w_is_r && (w_funct7 == 7'b0100000) && (w_funct3 == 3'b000);
  assign w_and  = w_is_r && (w_funct7 == 7'b0000000) && (w_funct3 == 3'b111);
  assign w_or   = w_is_r && (w_funct7 == 7'b0000000) && (w_funct3 == 3'b110);
  assign w_xor  = w_is_r && (w_funct7 == 7'b0000000) && (w_funct3 == 3'b100);
  assign w_slt  = w_is_r && (w_funct7 == 7'b0000000) && (w_funct3 == 3'b010);
  assign w_addi = (w_opcode == c_OP_I)   && (w_funct3 == 3'b000);
  assign w_lui  = (w_opcode == c_OP_LUI);
  assign w_lw   = (w_opcode == c_OP_LW)  && (w_funct3 == 3'b010);
  assign w_sw   = (w_opcode == c_OP_SW)  && (w_funct3 == 3'b010);
  assign w_beq  = (w_opcode == c_OP_BR)  && (w_funct3 == 3'b000);
  assign w_bne  = (w_opcode == c_OP_BR)  && (w_funct3 == 3'b001);
  assign w_jal  = (w_opcode == c_OP_JAL);

  // Only the register fields an instruction actually uses can make it illegal on a 16-register core
  assign w_uses_rd  = w_add | w_sub | w_and | w_or | w_xor | w_slt | w_addi | w_lui | w_lw | w_jal;
  assign w_uses_rs1 = w_add | w_sub | w_and | w_or | w_xor | w_slt | w_addi | w_lw | w_sw | w_beq | w_bne;
  assign w_uses_rs2 = w_add | w_sub | w_and | w_or | w_xor | w_slt | w_sw | w_beq | w_bne;
  assign w_reg_bad  = (NREG < 32) && ((w_uses_rd && w_rd[4]) || (w_uses_rs1 && w_rs1[4]) ||
                                      (w_uses_rs2 && w_rs2[4]));
  assign w_legal    = (w_uses_rd | w_uses_rs1) && !w_reg_bad;

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1[c_REG_AW-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2[c_REG_AW-1:0]];

  always_comb begin
    w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    if (w_sw)
      w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    else if (w_beq || w_bne)
      w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    else if (w_lui)
      w_imm = {r_ir[31:12], 12'h000};
    else if (w_jal)
      w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  end

  assign w_pc4 = r_pc + ADDR_W'(4);

  always_comb begin
    w_alu = r_a + r_b;
    if (w_lui)
      w_alu = r_imm;
    else if (w_jal)
      w_alu = 32'(w_pc4);
    else if (w_addi || w_lw || w_sw)
      w_alu = r_a + r_imm;
    else if (w_sub || w_beq || w_bne)
      w_alu = r_a - r_b;
    else if (w_and)
      w_alu = r_a & r_b;
    else if (w_or)
      w_alu = r_a | r_b;
    else if (w_xor)
      w_alu = r_a ^ r_b;
    else if (w_slt)
      w_alu = {31'h0, $signed(r_a) < $signed(r_b)};
  end

  assign w_take    = w_legal && ((w_beq && r_zero) || (w_bne && !r_zero) || w_jal);
  assign w_next_pc = w_take ? (r_pc + r_imm[ADDR_W-1:0]) : w_pc4;
  assign w_wb_en   = w_legal && w_uses_rd && (w_rd != 5'd0);
  assign w_wb_data = w_lw ? r_mdr : r_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= 32'h0;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_imm       <= 32'h0;
      r_alu       <= 32'h0;
      r_mdr       <= 32'h0;
      r_zero      <= 1'b0;
      r_retire    <= 1'b0;
      r_halted    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= RESET_PC;
      r_mem_wdata <= 32'h0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= 32'h0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // First cycle out of reset arrives here with no request raised yet
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (mem_ack) begin
            r_ir      <= mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= w_rs1_val;
          r_b     <= w_rs2_val;
          r_imm   <= w_imm;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu  <= w_alu;
          r_zero <= (w_alu == 32'h0);
          if (!w_legal) begin
`ifdef MULTICYCLE_CPU_TRAP_EN
            r_halted <= 1'b1;
            r_state  <= S_TRAP;
`else
            r_retire <= 1'b1;
            r_state  <= S_WB;
`endif
          end else if (w_lw || w_sw) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_sw;
            r_mem_addr  <= {w_alu[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= r_b;
            r_state     <= S_MEM;
          end else begin
            r_retire <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (!r_mem_we) r_mdr <= mem_rdata;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_retire  <= 1'b1;
            r_state   <= S_WB;
          end
        end
        S_WB: begin
          if (w_wb_en) r_regs[w_rd[c_REG_AW-1:0]] <= w_wb_data;
          r_pc       <= w_next_pc;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= w_next_pc;
          r_state    <= S_FETCH;
        end
`ifdef MULTICYCLE_CPU_TRAP_EN
        S_TRAP: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end
`endif
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_FETCH;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign zero      = r_zero;
  assign retire    = r_retire;
  assign halted    = r_halted;
  assign pc_out    = r_pc;

endmodule
`default_nettype wire
